// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 frame receiver:
//   - frame geometry constants (FRAME_BITS, DATA_BITS, SHIFT_BITS)
//   - receiver FSM state enum
//   - odd-parity helper used when a frame is checked
// ---------------------------------------------------------------------------
package ps2_pkg;

  // Full PS/2 frame: start + 8 data + parity + stop.
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;
  // The start bit is consumed in IDLE, so only data, parity and stop are
  // shifted into the frame register.
  localparam int SHIFT_BITS = FRAME_BITS - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_t;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number
  // of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                         input logic                 parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// ---------------------------------------------------------------------------
// ps2_sync_fifo
// Single-clock FIFO for received bytes. Pointers carry one extra wrap bit so
// that full and empty are distinguishable with DEPTH a power of two.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (empties the FIFO)
//   push       write push_data when not full (or when full with a pop)
//   push_data  WIDTH-bit write data
//   pop        remove the head entry; ignored while empty
//   pop_data   head entry, reads as zero while empty
//   full       DEPTH entries stored
//   empty      no entries stored
// ---------------------------------------------------------------------------
module ps2_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  // the write (it lands in the cell being vacated).
  assign do_push = push & (~full | do_pop);

  // Zero while empty so the output is defined straight out of reset even
  // though the storage array itself is never cleared.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked purely by the
  // pointers, so stale contents are never observable and the array can map
  // to plain RAM/register cells without reset wiring.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
// PS/2 device-to-host frame receiver. The raw PS/2 clock is synchronised and
// glitch-filtered; each filtered falling edge samples the synchronised data
// line. Complete frames are checked for stop bit and odd parity, and good
// bytes are buffered in a small FIFO.
//
// Parameters:
//   FILTER_LEN   ps2c glitch-filter length in clk cycles (2..16)
//   TIMEOUT_CYC  max clk cycles between ps2c falls inside a frame
//   FIFO_DEPTH   received-byte buffer depth (power of two, 2..16)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   ps2c, ps2d   raw PS/2 clock / data, asynchronous to clk
//   rx_en        permits the start of a new frame
//   dout         FIFO head byte
//   dout_valid   FIFO non-empty
//   dout_ready   pops the head when dout_valid & dout_ready
//   parity_err   one-cycle pulse: parity check failed
//   frame_err    one-cycle pulse: bad start bit or stop bit
//   timeout_err  one-cycle pulse: ps2c stalled inside a frame
//   overflow     one-cycle pulse: good byte dropped, FIFO full
//   busy         frame in progress
// ---------------------------------------------------------------------------
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       overflow,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    LAST_BIT = 4'(SHIFT_BITS - 1);

  // ---------------------------------------------------------------------
  // Input synchronisers and ps2c glitch filter
  // ---------------------------------------------------------------------
  logic                  c_s1, c_s2;
  logic                  d_s1, d_s2;
  logic [FILTER_LEN-1:0] filt;
  logic                  fc;
  logic                  fc_next;
  logic                  fall;

  // Lines idle high, so the synchronisers, filter and filtered clock all
  // reset to 1; this prevents a spurious edge when reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
      filt <= '1;
      fc   <= 1'b1;
    end else begin
      c_s1 <= ps2c;
      c_s2 <= c_s1;
      d_s1 <= ps2d;
      d_s2 <= d_s1;
      filt <= {filt[FILTER_LEN-2:0], c_s2};
      fc   <= fc_next;
    end
  end

  // The filtered clock only changes once FILTER_LEN consecutive samples
  // agree; anything shorter leaves it holding its previous level.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    fc_next = fc;
    if (&filt)       fc_next = 1'b1;
    else if (~|filt) fc_next = 1'b0;
  end

  assign fall = fc & ~fc_next;

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  ps2_state_t            state;
  logic [3:0]            bit_cnt;
  logic [TW-1:0]         tcnt;
  logic [SHIFT_BITS-1:0] shreg;
  logic                  push_q;

  // Frame register after SHIFT_BITS LSB-first shifts:
  //   [DATA_BITS-1:0] data, [DATA_BITS] parity, [SHIFT_BITS-1] stop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      tcnt        <= '0;
      shreg       <= '0;
      push_q      <= 1'b0;
      busy        <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle.
      push_q      <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (fall && rx_en) begin
            if (!d_s2) begin
              bit_cnt <= '0;
              tcnt    <= '0;
              busy    <= 1'b1;
              state   <= ST_SHIFT;
            end else begin
              // Line was high where a start bit belongs.
              frame_err <= 1'b1;
            end
          end
        end

        // rx_en is deliberately ignored here: once a frame has started it
        // always runs to completion or timeout.
        ST_SHIFT: begin
          if (fall) begin
            shreg   <= {d_s2, shreg[SHIFT_BITS-1:1]};
            tcnt    <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) state <= ST_CHECK;
          end else if (tcnt == T_LAST) begin
            // Device stopped clocking mid-frame: drop the partial byte.
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        ST_CHECK: begin
          // Stop-bit failure outranks parity; at most one pulse per frame.
          if (!shreg[SHIFT_BITS-1]) begin
            frame_err <= 1'b1;
          end else if (!odd_parity_ok(shreg[DATA_BITS-1:0], shreg[DATA_BITS])) begin
            parity_err <= 1'b1;
          end else begin
            push_q <= 1'b1;
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Received-byte FIFO and overflow detection
  // ---------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;

  // shreg is stable in IDLE, so it still holds the checked byte while
  // push_q is high.
  ps2_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (shreg[DATA_BITS-1:0]),
    .pop       (dout_ready),
    .pop_data  (dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign dout_valid = ~fifo_empty;

  // The FIFO silently refuses a write while full; flag that the byte was
  // lost unless a same-cycle pop made room for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= 1'b0;
    else      overflow <= push_q & fifo_full & ~(dout_ready & dout_valid);
  end

endmodule
